// File: rtl/armleocpu_multiplier_seq.sv
// Iterative multiplier for all four RISC-V M multiply forms. Each CALC cycle
// retires BITS_PER_CYCLE multiplier bits; one more cycle applies the sign and loads the outputs.
module armleocpu_multiplier_seq #(
    parameter int WIDTH          = 32,
    parameter int BITS_PER_CYCLE = 4
) (
    input  logic                 clk,
    input  logic                 rst,
    input  logic                 valid,
    input  logic [1:0]           mode,
    input  logic [WIDTH-1:0]     factor0,
    input  logic [WIDTH-1:0]     factor1,
    input  logic                 kill,
    output logic                 ready,
    output logic                 done,
    output logic [WIDTH-1:0]     result,
    output logic [2*WIDTH-1:0]   result_full
);

    localparam int N  = WIDTH / BITS_PER_CYCLE;
    localparam int AW = 2 * WIDTH;
    localparam int PW = WIDTH + BITS_PER_CYCLE;
    localparam int CW = $clog2(N + 1);
    localparam int SW = $clog2(AW);

    localparam logic [1:0] MODE_MUL    = 2'b00;
    localparam logic [1:0] MODE_MULH   = 2'b01;
    localparam logic [1:0] MODE_MULHSU = 2'b10;

    typedef enum logic [1:0] {
        IDLE = 2'd0,
        CALC = 2'd1,
        DONE = 2'd2
    } state_t;

    state_t           state_reg;
    logic [1:0]       mode_reg;
    logic [WIDTH-1:0] mcand_reg;
    logic [WIDTH-1:0] mplier_reg;
    logic             neg_reg;
    logic [CW-1:0]    counter_reg;
    logic [AW-1:0]    acc_reg;
    logic             done_reg;
    logic [WIDTH-1:0] result_reg;
    logic [AW-1:0]    result_full_reg;

    logic             sign0_en;
    logic             sign1_en;
    logic             neg0;
    logic             neg1;
    logic [WIDTH-1:0] mag0;
    logic [WIDTH-1:0] mag1;
    logic             accept;

    logic [PW-1:0]    pp_terms [BITS_PER_CYCLE];
    logic [PW-1:0]    partial;
    logic [SW-1:0]    shamt;
    logic [AW-1:0]    acc_next;
    logic [AW-1:0]    acc_final;

    assign ready  = (state_reg != CALC) && !rst;
    assign accept = valid && ready && !kill;

    // Magnitudes are taken in WIDTH bits: -2^(WIDTH-1) negates to 2^(WIDTH-1), which is
    // exactly representable as an unsigned WIDTH-bit value.
    assign sign0_en = (mode == MODE_MULH) || (mode == MODE_MULHSU);
    assign sign1_en = (mode == MODE_MULH);
    assign neg0     = sign0_en && factor0[WIDTH-1];
    assign neg1     = sign1_en && factor1[WIDTH-1];
    assign mag0     = neg0 ? (~factor0 + WIDTH'(1)) : factor0;
    assign mag1     = neg1 ? (~factor1 + WIDTH'(1)) : factor1;

    genvar gi;
    generate
        for (gi = 0; gi < BITS_PER_CYCLE; gi++) begin : g_pp
            assign pp_terms[gi] = mplier_reg[gi] ? (PW'(mcand_reg) << gi) : '0;
        end
    endgenerate

    always_comb begin
        partial = '0;
        for (int i = 0; i < BITS_PER_CYCLE; i++) begin
            partial = partial + pp_terms[i];
        end
    end

    assign shamt     = SW'(counter_reg) * SW'(BITS_PER_CYCLE);
    assign acc_next  = acc_reg + (AW'(partial) << shamt);
    assign acc_final = neg_reg ? (AW'(0) - acc_reg) : acc_reg;

    always_ff @(posedge clk) begin
        if (rst) begin
            state_reg       <= IDLE;
            mode_reg        <= MODE_MUL;
            mcand_reg       <= '0;
            mplier_reg      <= '0;
            neg_reg         <= 1'b0;
            counter_reg     <= '0;
            acc_reg         <= '0;
            done_reg        <= 1'b0;
            result_reg      <= '0;
            result_full_reg <= '0;
        end else begin
            done_reg <= 1'b0;
            case (state_reg)
                IDLE, DONE: begin
                    if (accept) begin
                        mode_reg    <= mode;
                        mcand_reg   <= mag0;
                        mplier_reg  <= mag1;
                        neg_reg     <= neg0 ^ neg1;
                        counter_reg <= '0;
                        acc_reg     <= '0;
                        state_reg   <= CALC;
                    end else begin
                        state_reg <= IDLE;
                    end
                end
                CALC: begin
                    if (kill) begin
                        state_reg <= IDLE;
                    end else if (counter_reg == CW'(N)) begin
                        // All multiplier digits consumed: apply sign, publish, pulse done.
                        result_full_reg <= acc_final;
                        result_reg      <= (mode_reg == MODE_MUL) ? acc_final[WIDTH-1:0]
                                                                  : acc_final[AW-1:WIDTH];
                        done_reg        <= 1'b1;
                        state_reg       <= DONE;
                    end else begin
                        acc_reg     <= acc_next;
                        mplier_reg  <= mplier_reg >> BITS_PER_CYCLE;
                        counter_reg <= counter_reg + CW'(1);
                    end
                end
                default: state_reg <= IDLE;
            endcase
        end
    end

    assign done        = done_reg;
    assign result      = result_reg;
    assign result_full = result_full_reg;

endmodule

// File: tb/tb_armleocpu_multiplier_seq.sv
// Bench for armleocpu_multiplier_seq: vector table and handshake corner cases on the
// 32-bit/4-bit configuration, plus a random sweep of three 16-bit configurations.
module tb_armleocpu_multiplier_seq;

    logic        clk = 1'b0;
    logic        rst;
    logic        valid;
    logic        kill;
    logic [1:0]  mode;
    logic [31:0] f0;
    logic [31:0] f1;
    logic        ready;
    logic        done;
    logic [31:0] result;
    logic [63:0] result_full;

    always #5 clk = ~clk;

    armleocpu_multiplier_seq #(.WIDTH(32), .BITS_PER_CYCLE(4)) dut (
        .clk(clk), .rst(rst), .valid(valid), .mode(mode), .factor0(f0), .factor1(f1),
        .kill(kill), .ready(ready), .done(done), .result(result), .result_full(result_full)
    );

    // 16-bit sweep instances, BITS_PER_CYCLE = 1, 2, 16 -> latencies 17, 9, 2
    logic        s_valid;
    logic [1:0]  s_mode;
    logic [15:0] s_f0;
    logic [15:0] s_f1;
    logic        s_ready  [3];
    logic        s_done   [3];
    logic [15:0] s_result [3];
    logic [31:0] s_full   [3];

    genvar gi;
    generate
        for (gi = 0; gi < 3; gi++) begin : g_sweep
            localparam int BPC = (gi == 0) ? 1 : (gi == 1) ? 2 : 16;
            armleocpu_multiplier_seq #(.WIDTH(16), .BITS_PER_CYCLE(BPC)) sdut (
                .clk(clk), .rst(rst), .valid(s_valid), .mode(s_mode), .factor0(s_f0),
                .factor1(s_f1), .kill(1'b0), .ready(s_ready[gi]), .done(s_done[gi]),
                .result(s_result[gi]), .result_full(s_full[gi])
            );
        end
    endgenerate

    typedef struct {
        logic [1:0]  mode;
        logic [31:0] f0;
        logic [31:0] f1;
        logic [31:0] exp_res;
        logic [63:0] exp_full;
        bit          chk_full;
    } vec_t;

    typedef struct {
        logic [31:0] res;
        logic [63:0] full;
        bit          chk_full;
    } exp_t;

    exp_t exp_q[$];
    int   vectors     = 0;
    int   miscompares = 0;

    task automatic check(input string name, input logic [63:0] act, input logic [63:0] req);
        vectors++;
        if (act !== req) begin
            miscompares++;
            $display("FAIL %s: got 0x%0h, expected 0x%0h", name, act, req);
        end else begin
            $display("ok   %s: 0x%0h", name, act);
        end
    endtask

    task automatic push_exp(input logic [31:0] res, input logic [63:0] full, input bit chk);
        exp_t e;
        e.res = res;
        e.full = full;
        e.chk_full = chk;
        exp_q.push_back(e);
    endtask

    // Called at a negedge; returns just after the accepting posedge.
    task automatic send(input logic [1:0] m, input logic [31:0] a, input logic [31:0] b);
        valid = 1'b1;
        mode  = m;
        f0    = a;
        f1    = b;
        @(posedge clk);
        #1 valid = 1'b0;
    endtask

    // Waits for done, checks latency and pops the scoreboard; returns at the done negedge.
    task automatic wait_done(input string name, input int exp_lat);
        int   edges = 0;
        bit   seen  = 0;
        exp_t e;
        while (!seen && edges < exp_lat + 8) begin
            @(posedge clk);
            edges++;
            @(negedge clk);
            if (done) seen = 1;
        end
        if (!seen) begin
            vectors++;
            miscompares++;
            $display("FAIL %s.done: no done within %0d edges, expected after %0d", name, edges, exp_lat);
        end else begin
            check({name, ".latency"}, 64'(edges), 64'(exp_lat));
            if (exp_q.size() == 0) begin
                vectors++;
                miscompares++;
                $display("FAIL %s.scoreboard: done with result 0x%0h, expected no done", name, result);
            end else begin
                e = exp_q.pop_front();
                check({name, ".result"}, 64'(result), 64'(e.res));
                if (e.chk_full) check({name, ".result_full"}, result_full, e.full);
            end
        end
    endtask

    task automatic count_dones(input int cycles, output int n);
        n = 0;
        repeat (cycles) begin
            @(negedge clk);
            if (done) n++;
        end
    endtask

    function automatic logic [31:0] model16(input logic [1:0] m, input logic [15:0] a,
                                            input logic [15:0] b);
        logic signed [33:0] ea;
        logic signed [33:0] eb;
        logic signed [67:0] p;
        ea = (m == 2'b01 || m == 2'b10) ? {{18{a[15]}}, a} : {18'b0, a};
        eb = (m == 2'b01) ? {{18{b[15]}}, b} : {18'b0, b};
        p  = ea * eb;
        return p[31:0];
    endfunction

    initial begin
        #500000;
        $display("FAIL global_timeout: simulation did not finish, expected $finish");
        $fatal(1);
    end

    initial begin
        vec_t vecs[11];
        int   n;
        int   lat_tab[3];
        bit   got[3];
        logic [1:0]  sm;
        logic [15:0] sa, sb;
        logic [31:0] sfull;
        logic [15:0] sres;
        int   edges;

        vecs[0]  = '{2'b11, 32'hFFFFFFFF, 32'hFFFFFFFF, 32'hFFFFFFFE, 64'hFFFFFFFE00000001, 1'b1};
        vecs[1]  = '{2'b01, 32'h80000000, 32'h80000000, 32'h40000000, 64'h4000000000000000, 1'b1};
        vecs[2]  = '{2'b00, 32'h80000000, 32'hFFFFFFFF, 32'h80000000, 64'h0, 1'b0};
        vecs[3]  = '{2'b10, 32'hFFFFFFFF, 32'hFFFFFFFF, 32'hFFFFFFFF, 64'hFFFFFFFF00000001, 1'b1};
        vecs[4]  = '{2'b00, 32'd7,        32'd6,        32'd42,       64'h0, 1'b0};
        vecs[5]  = '{2'b00, 32'd3,        32'hFFFFFFFB, 32'hFFFFFFF1, 64'h0, 1'b0};
        vecs[6]  = '{2'b01, 32'hFFFFFFFD, 32'd7,        32'hFFFFFFFF, 64'hFFFFFFFFFFFFFFEB, 1'b1};
        vecs[7]  = '{2'b01, 32'h7FFFFFFF, 32'h80000000, 32'hC0000000, 64'hC000000080000000, 1'b1};
        vecs[8]  = '{2'b10, 32'h80000000, 32'h80000000, 32'hC0000000, 64'hC000000000000000, 1'b1};
        vecs[9]  = '{2'b11, 32'h80000000, 32'd2,        32'd1,        64'h0000000100000000, 1'b1};
        vecs[10] = '{2'b01, 32'd0,        32'hFFFFFFFF, 32'd0,        64'h0, 1'b1};

        rst = 1'b1; valid = 1'b0; kill = 1'b0; mode = 2'b00; f0 = '0; f1 = '0;
        s_valid = 1'b0; s_mode = 2'b00; s_f0 = '0; s_f1 = '0;

        // Reset state
        repeat (3) @(negedge clk);
        check("reset.ready", 64'(ready), 64'd0);
        check("reset.done", 64'(done), 64'd0);
        check("reset.result", 64'(result), 64'd0);
        check("reset.result_full", result_full, 64'd0);
        rst = 1'b0;
        @(negedge clk);
        check("idle.ready", 64'(ready), 64'd1);

        // Table vectors
        for (int i = 0; i < 11; i++) begin
            push_exp(vecs[i].exp_res, vecs[i].exp_full, vecs[i].chk_full);
            send(vecs[i].mode, vecs[i].f0, vecs[i].f1);
            wait_done($sformatf("vec%0d", i), 9);
            @(negedge clk);
            check($sformatf("vec%0d.done_pulse", i), 64'(done), 64'd0);
        end

        // Back-to-back: second request held in the DONE cycle
        push_exp(32'd42, 64'd42, 1'b1);
        send(2'b00, 32'd7, 32'd6);
        wait_done("b2b_first", 9);
        check("b2b.ready_in_done", 64'(ready), 64'd1);
        push_exp(32'hFFFFFFF1, 64'h0, 1'b0);
        send(2'b00, 32'd3, 32'hFFFFFFFB);
        wait_done("b2b_second", 9);
        @(negedge clk);

        // Kill on CALC edge 4
        send(2'b00, 32'd5, 32'd5);
        repeat (3) @(posedge clk);
        @(negedge clk);
        kill = 1'b1;
        @(posedge clk);
        #1 kill = 1'b0;
        @(negedge clk);
        check("kill.ready", 64'(ready), 64'd1);
        check("kill.done", 64'(done), 64'd0);
        check("kill.result_held", 64'(result), 64'hFFFFFFF1);
        count_dones(15, n);
        check("kill.no_done", 64'(n), 64'd0);
        push_exp(32'd6, 64'd6, 1'b1);
        send(2'b00, 32'd2, 32'd3);
        wait_done("after_kill", 9);
        @(negedge clk);

        // Kill on the accept edge drops the request
        valid = 1'b1; kill = 1'b1; mode = 2'b00; f0 = 32'd4; f1 = 32'd4;
        @(posedge clk);
        #1 begin valid = 1'b0; kill = 1'b0; end
        @(negedge clk);
        check("kill_accept.ready", 64'(ready), 64'd1);
        count_dones(15, n);
        check("kill_accept.no_done", 64'(n), 64'd0);

        // valid during CALC is ignored
        push_exp(32'd81, 64'd81, 1'b1);
        send(2'b00, 32'd9, 32'd9);
        repeat (2) @(posedge clk);
        @(negedge clk);
        valid = 1'b1; f0 = 32'd100; f1 = 32'd100;
        repeat (3) @(negedge clk);
        valid = 1'b0;
        wait_done("calc_valid", 4);
        count_dones(15, n);
        check("calc_valid.extra_done", 64'(n), 64'd0);

        // Reset mid-CALC
        send(2'b00, 32'd11, 32'd11);
        repeat (4) @(posedge clk);
        @(negedge clk);
        rst = 1'b1;
        @(negedge clk);
        check("rst_mid.ready", 64'(ready), 64'd0);
        check("rst_mid.done", 64'(done), 64'd0);
        check("rst_mid.result", 64'(result), 64'd0);
        check("rst_mid.result_full", result_full, 64'd0);
        rst = 1'b0;
        @(negedge clk);
        check("rst_mid.idle_ready", 64'(ready), 64'd1);
        count_dones(15, n);
        check("rst_mid.no_done", 64'(n), 64'd0);

        // WIDTH=16 sweep
        lat_tab[0] = 17; lat_tab[1] = 9; lat_tab[2] = 2;
        for (int i = 0; i < 24; i++) begin
            case (i)
                0:       begin sm = 2'b01; sa = 16'h8000; sb = 16'h8000; end
                1:       begin sm = 2'b11; sa = 16'hFFFF; sb = 16'hFFFF; end
                2:       begin sm = 2'b10; sa = 16'hFFFF; sb = 16'hFFFF; end
                3:       begin sm = 2'b00; sa = 16'h8000; sb = 16'hFFFF; end
                default: begin
                    sm = 2'($urandom_range(0, 3));
                    sa = 16'($urandom);
                    sb = 16'($urandom);
                end
            endcase
            sfull = model16(sm, sa, sb);
            sres  = (sm == 2'b00) ? sfull[15:0] : sfull[31:16];
            s_valid = 1'b1; s_mode = sm; s_f0 = sa; s_f1 = sb;
            @(posedge clk);
            #1 s_valid = 1'b0;
            for (int k = 0; k < 3; k++) got[k] = 1'b0;
            edges = 0;
            while (!(got[0] && got[1] && got[2]) && edges < 25) begin
                @(posedge clk);
                edges++;
                @(negedge clk);
                for (int k = 0; k < 3; k++) begin
                    if (!got[k] && s_done[k]) begin
                        got[k] = 1'b1;
                        check($sformatf("sweep%0d.cfg%0d.latency", i, k), 64'(edges), 64'(lat_tab[k]));
                        check($sformatf("sweep%0d.cfg%0d.result", i, k), 64'(s_result[k]), 64'(sres));
                        if (sm != 2'b00)
                            check($sformatf("sweep%0d.cfg%0d.result_full", i, k), 64'(s_full[k]), 64'(sfull));
                    end
                end
            end
            for (int k = 0; k < 3; k++) begin
                if (!got[k]) begin
                    vectors++;
                    miscompares++;
                    $display("FAIL sweep%0d.cfg%0d.done: no done within %0d edges, expected after %0d",
                             i, k, edges, lat_tab[k]);
                end
            end
            @(negedge clk);
        end

        if (exp_q.size() != 0) begin
            vectors++;
            miscompares++;
            $display("FAIL scoreboard.drain: %0d results outstanding, expected 0", exp_q.size());
        end

        $display("== %0d vectors applied, %0d miscompares ==", vectors, miscompares);
        $finish;
    end

endmodule
